// File: rtl/bcd_display_formatter_pkg.sv
// Shared constants, FSM encoding and digit-blanking helper for the LED display formatter.
// The packed word always holds six 4-bit digit codes, with digit0 in the low nibble.
package led_disp_pkg;

   localparam int         DIGITS     = 6;
   localparam int         BCD_W      = 28;
   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [3:0] ERR_CODE   = 4'hE;
   localparam logic [3:0] NO_DOT     = 4'hF;
   localparam logic [3:0] MAX_DOT    = 4'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FORMAT = 2'd2
   } state_t;

   // Leading zeros go dark. Digit0 and any digit at or below a valid dot stay lit.
   function automatic logic [23:0] blank_leading(input logic [23:0] digits,
                                                 input logic [3:0]  dot);
      logic [23:0] res;
      logic        lead;
      res  = digits;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (digits[i*4 +: 4] == 4'h0) && !((dot <= MAX_DOT) && (i <= int'(dot)))) begin
            res[i*4 +: 4] = BLANK_CODE;
         end else begin
            lead = 1'b0;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_display_formatter_if.sv
// Request/result bundle between the status source, the formatter and the 7-segment driver.
interface bcd_display_formatter_if #(parameter int IN_W = 20);

   logic [IN_W-1:0] bin_in;
   logic [3:0]      dot_pos;
   logic            bin_valid;
   logic            bin_ready;
   logic [23:0]     data_out;
   logic [3:0]      dot_index;
   logic            overflow;
   logic            done;

   modport master (
      output bin_in, dot_pos, bin_valid,
      input  bin_ready, data_out, dot_index, overflow, done
   );

   modport slave (
      input  bin_in, dot_pos, bin_valid,
      output bin_ready, data_out, dot_index, overflow, done
   );

endinterface

// File: rtl/bcd_display_formatter_digit_adj.sv
// One double-dabble correction step: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   // add-3 correction so the following left shift carries correctly into the next digit
   always_comb begin
      if (digit_in >= 4'd5) begin
         digit_out = digit_in + 4'd3;
      end else begin
         digit_out = digit_in;
      end
   end

endmodule

// File: rtl/bcd_display_formatter.sv
// Sequential binary-to-BCD converter producing the packed six-digit code word for the
// 7-segment driver, with leading-zero blanking and overflow indication.
module bcd_display_formatter
   import led_disp_pkg::*;
#(
   parameter int IN_W        = 20,
   parameter bit BLANK_ZEROS = 1'b1
) (
   input  logic                    CLK,
   input  logic                    RST,
   bcd_display_formatter_if.slave  bus
);

   localparam int               CNT_W      = 5;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 1);

   state_t            state_r;
   logic [IN_W-1:0]   shift_r;
   logic [BCD_W-1:0]  bcd_r;
   logic [BCD_W-1:0]  bcd_adj_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [3:0]        dot_r;
   logic              ready_r;
   logic [23:0]       data_r;
   logic [3:0]        dot_index_r;
   logic              overflow_r;
   logic              done_r;
   logic              overflow_s;
   logic [23:0]       format_s;

   for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (bcd_r[g*4 +: 4]),
         .digit_out (bcd_adj_s[g*4 +: 4])
      );
   end

   // Final display word from the finished accumulator; only captured in FORMAT
   always_comb begin
      overflow_s = (bcd_r[BCD_W-1 -: 4] != 4'h0);
      if (overflow_s) begin
         format_s = {DIGITS{ERR_CODE}};
      end else if (BLANK_ZEROS) begin
         format_s = blank_leading(bcd_r[23:0], dot_r);
      end else begin
         format_s = bcd_r[23:0];
      end
   end

   // Conversion FSM with shift register, counter and held output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= IDLE;
         shift_r     <= '0;
         bcd_r       <= '0;
         cnt_r       <= '0;
         dot_r       <= NO_DOT;
         ready_r     <= 1'b0;
         data_r      <= {DIGITS{BLANK_CODE}};
         dot_index_r <= NO_DOT;
         overflow_r  <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               ready_r <= 1'b1;
               if (bus.bin_valid && ready_r) begin
                  shift_r <= bus.bin_in;
                  bcd_r   <= '0;
                  dot_r   <= bus.dot_pos;
                  cnt_r   <= '0;
                  ready_r <= 1'b0;
                  state_r <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[IN_W-1]};
               shift_r <= shift_r << 1'b1;
               cnt_r   <= cnt_r + 5'd1;
               if (cnt_r == LAST_SHIFT) begin
                  state_r <= FORMAT;
               end
            end
            FORMAT: begin
               data_r      <= format_s;
               dot_index_r <= dot_r;
               overflow_r  <= overflow_s;
               done_r      <= 1'b1;
               ready_r     <= 1'b1;
               state_r     <= IDLE;
            end
            default: begin
               ready_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.bin_ready = ready_r;
   assign bus.data_out  = data_r;
   assign bus.dot_index = dot_index_r;
   assign bus.overflow  = overflow_r;
   assign bus.done      = done_r;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Scoreboard bench: stimulus pushes expected words from an arithmetic reference model,
// a negedge monitor pops and compares on every done pulse and checks hold/reset values.
module tb_bcd_display_formatter;

   localparam int IN_W   = 20;
   localparam int LAT    = IN_W + 1;
   localparam int PERIOD = IN_W + 2;

   typedef struct {
      logic [23:0] data;
      logic [3:0]  dot;
      logic        ovf;
      int          acc;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic rst_q = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   bit   hold_mode = 1'b0;
   int   n_acc = 0;

   exp_t q_b[$];
   exp_t q_n[$];

   always #5 CLK = ~CLK;

   bcd_display_formatter_if #(.IN_W(IN_W)) bus_b ();
   bcd_display_formatter_if #(.IN_W(IN_W)) bus_n ();

   assign bus_n.bin_in    = bus_b.bin_in;
   assign bus_n.dot_pos   = bus_b.dot_pos;
   assign bus_n.bin_valid = bus_b.bin_valid;

   bcd_display_formatter #(.IN_W(IN_W), .BLANK_ZEROS(1'b1)) u_dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_b.slave)
   );

   bcd_display_formatter #(.IN_W(IN_W), .BLANK_ZEROS(1'b0)) u_dut_nb (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_n.slave)
   );

   always @(posedge CLK) begin
      cyc   <= cyc + 1;
      rst_q <= RST;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decimal digits by division; digit i is dark when the value is below 10^i
   function automatic logic [23:0] model(input int unsigned v, input logic [3:0] d, input bit blank);
      logic [23:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      if (v > 999999) return 24'hEEEEEE;
      for (int i = 0; i < 6; i++) begin
         if (blank && i > 0 && v < p && !(d <= 4'd5 && i <= int'(d)))
            r[i*4 +: 4] = 4'hF;
         else
            r[i*4 +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   logic [23:0] last_b = 24'hFFFFFF;
   logic [23:0] last_n = 24'hFFFFFF;
   logic [3:0]  last_dot = 4'hF;
   logic        last_ovf = 1'b0;
   logic        prev_done = 1'b0;
   int          prev_acc = -1;

   always @(negedge CLK) begin
      exp_t e;
      if (rst_q) begin
         check("rst_done", bus_b.done, 1'b0);
         check("rst_data", bus_b.data_out, 24'hFFFFFF);
         check("rst_dot", bus_b.dot_index, 4'hF);
         check("rst_ovf", bus_b.overflow, 1'b0);
         check("rst_data_nb", bus_n.data_out, 24'hFFFFFF);
         check("rst_done_nb", bus_n.done, 1'b0);
         if (RST) check("rst_ready", bus_b.bin_ready, 1'b0);
      end else begin
         if (!RST && bus_b.bin_valid && bus_b.bin_ready) begin
            e.data = model(int'(bus_b.bin_in), bus_b.dot_pos, 1'b1);
            e.dot  = bus_b.dot_pos;
            e.ovf  = (int'(bus_b.bin_in) > 999999);
            e.acc  = cyc + 1;
            q_b.push_back(e);
            e.data = model(int'(bus_b.bin_in), bus_b.dot_pos, 1'b0);
            q_n.push_back(e);
            if (prev_acc >= 0) begin
               if (hold_mode) check("accept_spacing", cyc + 1 - prev_acc, PERIOD);
               else           check("accept_gap_min", (cyc + 1 - prev_acc) >= PERIOD, 1'b1);
            end
            prev_acc = cyc + 1;
            n_acc++;
         end
         if (bus_b.done) begin
            check("done_width", prev_done, 1'b0);
            if (q_b.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 required no pending request (t=%0t)", $time);
            end else begin
               e = q_b.pop_front();
               check("data_out", bus_b.data_out, e.data);
               check("dot_index", bus_b.dot_index, e.dot);
               check("overflow", bus_b.overflow, e.ovf);
               check("latency", cyc - e.acc, LAT);
               last_b = e.data;
               last_dot = e.dot;
               last_ovf = e.ovf;
            end
         end else begin
            check("hold_data", bus_b.data_out, last_b);
            check("hold_dot", bus_b.dot_index, last_dot);
            check("hold_ovf", bus_b.overflow, last_ovf);
         end
         if (bus_n.done) begin
            if (q_n.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done_nb: got done=1 required no pending request (t=%0t)", $time);
            end else begin
               e = q_n.pop_front();
               check("data_out_nb", bus_n.data_out, e.data);
               last_n = e.data;
            end
         end else begin
            check("hold_data_nb", bus_n.data_out, last_n);
         end
         prev_done = bus_b.done;
      end
      if (RST) begin
         q_b.delete();
         q_n.delete();
         last_b = 24'hFFFFFF;
         last_n = 24'hFFFFFF;
         last_dot = 4'hF;
         last_ovf = 1'b0;
         prev_done = 1'b0;
         prev_acc = -1;
      end
   end

   task automatic send(input int unsigned v, input logic [3:0] d);
      bit ok;
      ok = 1'b0;
      bus_b.bin_in    = IN_W'(v);
      bus_b.dot_pos   = d;
      bus_b.bin_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge CLK);
         if (bus_b.bin_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept_timeout", ok, 1'b1);
      @(posedge CLK);
      #2;
      bus_b.bin_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         if (bus_b.done) begin
            seen = 1'b1;
            check("ready_after_done", bus_b.bin_ready, 1'b1);
            break;
         end
      end
      check("done_timeout", seen, 1'b1);
      @(posedge CLK);
      #2;
   endtask

   initial begin
      int base;
      int unsigned v;
      logic [3:0] d;
      bus_b.bin_in    = '0;
      bus_b.dot_pos   = 4'hF;
      bus_b.bin_valid = 1'b0;
      repeat (3) @(posedge CLK);
      #2;
      RST = 1'b0;
      @(posedge CLK);
      #2;
      check("ready_after_reset", bus_b.bin_ready, 1'b1);

      send(123456, 4'hF); wait_done();
      send(42, 4'hF);     wait_done();
      send(0, 4'hF);      wait_done();
      send(5, 4'd2);      wait_done();
      send(999999, 4'd0); wait_done();
      send(1000000, 4'hF); wait_done();
      send(7, 4'hF);      wait_done();

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 9);
            1:       v = $urandom_range(0, 9999);
            2:       v = $urandom_range(990000, 1048575);
            default: v = $urandom_range(0, 1048575);
         endcase
         case ($urandom_range(0, 7))
            6:       d = 4'hF;
            7:       d = 4'($urandom_range(6, 14));
            default: d = 4'($urandom_range(0, 5));
         endcase
         send(v, d);
      end
      wait_done();

      send(123, 4'hF);
      repeat (9) @(posedge CLK);
      #2;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #2;
      RST = 1'b0;
      hold_mode = 1'b1;
      base = n_acc;
      bus_b.bin_in    = IN_W'(77);
      bus_b.dot_pos   = 4'hF;
      bus_b.bin_valid = 1'b1;
      repeat (100) @(posedge CLK);
      #2;
      bus_b.bin_valid = 1'b0;
      check("held_accepts_ge4", (n_acc - base) >= 4, 1'b1);
      hold_mode = 1'b0;

      for (int n = 0; n < 60 && q_b.size() != 0; n++) @(posedge CLK);
      #2;
      check("queue_drained", q_b.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish before 500000");
      $fatal(1, "watchdog");
   end

endmodule
